// File: rtl/instr_fetch_pkg.sv
// Shared types and encodings for the instruction fetch unit.
// Opcode and register codes describe the program word layout {op, arg, arg}.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [3:0] OP_LOAD = 4'b0000;
  localparam logic [3:0] OP_MOVE = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_BR   = 4'b1000;

  localparam logic [2:0] REG_NA = 3'd0;
  localparam logic [2:0] REG_R1 = 3'd1;
  localparam logic [2:0] REG_R2 = 3'd2;
  localparam logic [2:0] REG_R3 = 3'd3;
  localparam logic [2:0] REG_R4 = 3'd4;
  localparam logic [2:0] REG_R5 = 3'd5;
  localparam logic [2:0] REG_R6 = 3'd6;
  localparam logic [2:0] REG_PC = 3'd7;

  // Builds a word for the default field widths (4-bit op, two 3-bit args).
  function automatic logic [9:0] enc_instr(
    input logic [3:0] op,
    input logic [2:0] a,
    input logic [2:0] b
  );
    return {op, a, b};
  endfunction

endpackage

// File: rtl/ret_stack.sv
// LIFO of return addresses for the fetch unit.
// Push is ignored when full, pop is ignored when empty.
module ret_stack #(
  parameter  int WIDTH = 6,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW:0]      cnt;
  logic [PW-1:0]    top_ptr;

  assign top_ptr  = cnt[PW-1:0] - PW'(1);
  assign pop_data = store[top_ptr];
  assign full     = (cnt == (PW+1)'(DEPTH));
  assign empty    = (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (push && !full) begin
      cnt <= cnt + (PW+1)'(1);
    end else if (pop && !empty) begin
      cnt <= cnt - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push && !full) begin
      store[cnt[PW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Program memory + PC sequencer with LOAD/RUN/HALT control.
// Define CALL_STACK_EN to add the call/ret return stack.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter  int OP_SIZE     = 4,
  parameter  int ARG_SIZE    = 3,
  parameter  int ARG_NUM     = 2,
  parameter  int ADDR_W      = 6,
  parameter  int STACK_DEPTH = 4,
  localparam int IW          = OP_SIZE + ARG_NUM * ARG_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [IW-1:0]     wr_data,
  input  logic              done,
  input  logic              branch,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic              call,
  input  logic              ret,
  output logic [IW-1:0]     instruction,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              stack_err
);

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc_n;
  logic [ADDR_W-1:0] pc_inc;
  logic              run;
  logic [IW-1:0]     mem [2**ADDR_W];

  assign run         = (state == ST_RUN);
  assign pc_inc      = pc + ADDR_W'(1);
  assign instr_valid = run;
  assign halted      = (state == ST_HALT);
  assign instruction = run ? mem[pc] : '0;

  // Memory is never reset so a program survives rst.
  always_ff @(posedge clk) begin
    if (!rst && state == ST_LOAD && wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

`ifdef CALL_STACK_EN
  logic              full, empty;
  logic              push, pop;
  logic [ADDR_W-1:0] top;
  logic              err;

  assign push      = run & call & ~ret & ~full;
  assign pop       = run & ret & ~empty;
  assign stack_err = err;

  ret_stack #(
    .WIDTH(ADDR_W),
    .DEPTH(STACK_DEPTH)
  ) u_stack (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .push_data(pc_inc),
    .pop_data (top),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (run && ((ret && empty) || (!ret && call && full))) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_ok;
  assign unused_ok = ^{call, ret};
  assign stack_err = 1'b0;
`endif

  always_comb begin
    state_n = state;
    pc_n    = pc;
    unique case (state)
      ST_LOAD: begin
        if (start) state_n = ST_RUN;
      end
      ST_RUN: begin
`ifdef CALL_STACK_EN
        if (ret) begin
          if (empty) state_n = ST_HALT;
          else       pc_n    = top;
        end else if (call) begin
          if (full) state_n = ST_HALT;
          else      pc_n    = branch_addr;
        end else
`endif
        if (branch) begin
          pc_n = branch_addr;
        end else if (done) begin
          if (&pc) state_n = ST_HALT;
          else     pc_n    = pc_inc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_LOAD;
      pc    <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a queue-based reference model
// predicts each cycle, a negedge monitor pops and compares.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam int AW    = 6;
  localparam int IW    = 10;
  localparam int DEPTH = 64;
  localparam int SD    = 4;
`ifdef CALL_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic          clk, rst, start, wr_en, done, branch, call, ret;
  logic [AW-1:0] wr_addr, branch_addr, pc;
  logic [IW-1:0] wr_data, instruction;
  logic          instr_valid, halted, stack_err;

  instr_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .done       (done),
    .branch     (branch),
    .branch_addr(branch_addr),
    .call       (call),
    .ret        (ret),
    .instruction(instruction),
    .instr_valid(instr_valid),
    .pc         (pc),
    .halted     (halted),
    .stack_err  (stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] ins;
    logic          v;
    logic          h;
    logic          e;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: 0=LOAD 1=RUN 2=HALT, stack as a queue.
  logic [IW-1:0] mmem [DEPTH];
  int            mst  = 0;
  logic [AW-1:0] mpc  = '0;
  logic [AW-1:0] mstk[$];
  logic          merr = 1'b0;

  task automatic idle();
    rst = 0; start = 0; wr_en = 0; wr_addr = '0; wr_data = '0;
    done = 0; branch = 0; branch_addr = '0; call = 0; ret = 0;
  endtask

  task automatic model_step();
    exp_t e;
    if (rst) begin
      mst = 0; mpc = '0; mstk.delete(); merr = 1'b0;
    end else if (mst == 0) begin
      if (wr_en) mmem[wr_addr] = wr_data;
      if (start) mst = 1;
    end else if (mst == 1) begin
      if (STK && ret) begin
        if (mstk.size() == 0) begin merr = 1'b1; mst = 2; end
        else mpc = mstk.pop_back();
      end else if (STK && call) begin
        if (mstk.size() == SD) begin merr = 1'b1; mst = 2; end
        else begin mstk.push_back(AW'(mpc + 1)); mpc = branch_addr; end
      end else if (branch) begin
        mpc = branch_addr;
      end else if (done) begin
        if (int'(mpc) == DEPTH - 1) mst = 2;
        else mpc = AW'(mpc + 1);
      end
    end
    e.pc  = mpc;
    e.ins = (mst == 1) ? mmem[mpc] : '0;
    e.v   = (mst == 1);
    e.h   = (mst == 2);
    e.e   = merr;
    q.push_back(e);
  endtask

  task automatic step();
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      cur = q.pop_front();
      chk("pc", 32'(pc), 32'(cur.pc));
      chk("instruction", 32'(instruction), 32'(cur.ins));
      chk("instr_valid", 32'(instr_valid), 32'(cur.v));
      chk("halted", 32'(halted), 32'(cur.h));
      chk("stack_err", 32'(stack_err), 32'(cur.e));
    end
  end

  task automatic do_reset();
    idle(); rst = 1; step(); rst = 0;
  endtask

  logic [IW-1:0] prog [3];

  initial begin
    prog[0] = enc_instr(OP_LOAD, REG_R1, REG_NA);
    prog[1] = enc_instr(OP_ADD, REG_R1, REG_R2);
    prog[2] = enc_instr(OP_XOR, REG_R2, REG_R1);
    idle();
    @(negedge clk);
    #1;
    do_reset();

    for (int i = 0; i < DEPTH; i++) begin
      idle(); wr_en = 1; wr_addr = AW'(i);
      wr_data = (i < 3) ? prog[i] : IW'($urandom);
      step();
    end
    // Write and start in the same LOAD cycle.
    idle(); wr_en = 1; wr_addr = 6'd3; wr_data = IW'($urandom); start = 1;
    step();
    idle(); done = 1; step(); step(); step();
    idle(); branch = 1; branch_addr = 6'd20; done = 1; step();
    idle(); branch = 1; branch_addr = 6'd5; step();
    idle(); call = 1; branch_addr = 6'd40; step();
    idle(); ret = 1; step();
    idle(); step();
    for (int i = 0; i < 5; i++) begin
      idle(); call = 1; branch_addr = 6'd40; step();
    end
    idle(); done = 1; step();
    do_reset();

    idle(); start = 1; step();
    idle(); ret = 1; step();
    idle(); done = 1; branch = 1; branch_addr = 6'd9; step();
    do_reset();

    idle(); start = 1; step();
    idle(); wr_en = 1; wr_addr = '0; wr_data = ~mmem[0]; step();
    idle(); branch = 1; branch_addr = 6'd62; step();
    idle(); done = 1; step(); step(); step();
    do_reset();
    idle(); start = 1; step();
    idle(); step();

    for (int i = 0; i < 900; i++) begin
      idle();
      if ($urandom_range(0, 99) < 2 || (mst == 2 && $urandom_range(0, 3) == 0))
        rst = 1;
      wr_en       = 1'($urandom);
      wr_addr     = AW'($urandom);
      wr_data     = IW'($urandom);
      start       = ($urandom_range(0, 5) == 0);
      done        = 1'($urandom);
      branch      = ($urandom_range(0, 7) == 0);
      branch_addr = AW'($urandom);
      call        = ($urandom_range(0, 6) == 0);
      ret         = ($urandom_range(0, 6) == 0);
      step();
    end

    idle();
    step();
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
